// File: rtl/random_pkg.sv
// Shared constants and helpers for the card-value random generator.
// Holds the LFSR geometry and the card-value reduction.
package random_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Feedback taps at bits 15, 13, 12 and 10 (x^16+x^14+x^13+x^11+1)
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

  localparam int DEFAULT_MAX_CARD = 10;

  // Remainder against a constant divisor; synthesizes to a combinational reduction
  function automatic logic [3:0] to_card(input logic [LFSR_W-1:0] value,
                                         input logic [LFSR_W-1:0] max_card);
    logic [LFSR_W-1:0] sum;
    sum = (value % max_card) + LFSR_W'(1);
    return sum[3:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with the seed on reset.
// The seed must be nonzero; the all-zero state is never reached.
module lfsr16
  import random_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic fb;

  assign fb = ^(state & TAP_MASK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= seed;
    end else begin
      state <= {state[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/random_design.sv
// Card draw: on each rising edge of EN, latch (lfsr mod MAX_CARD)+1
// and hold it on r3..r0; zero means no card drawn since reset.
module random_design
  import random_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
  parameter int                MAX_CARD = DEFAULT_MAX_CARD
)
(
  input  logic CLK,
  input  logic CLR,
  input  logic EN,
  output logic r3,
  output logic r2,
  output logic r1,
  output logic r0
);

  // A zero seed would lock the LFSR, so substitute 1
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr;
  logic              en_d;
  logic [3:0]        card;

  lfsr16 u_lfsr (
    .clk   (CLK),
    .rst_n (CLR),
    .seed  (SEED_EFF),
    .state (lfsr)
  );

  // Draw uses the pre-edge LFSR value; holding EN high draws only once
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      en_d <= 1'b0;
      card <= '0;
    end else begin
      en_d <= EN;
      if (EN && !en_d) begin
        card <= to_card(lfsr, LFSR_W'(MAX_CARD));
      end
    end
  end

  assign {r3, r2, r1, r0} = card;

endmodule

// File: tb/tb_random_design.sv
// Self-checking bench for random_design: reference LFSR model feeds a
// scoreboard queue of expected card values, compared after each clock edge.
module tb_random_design;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic EN  = 1'b0;
  logic r3, r2, r1, r0;
  logic [3:0] card_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_en_d = 1'b0;
  logic [3:0]  m_card = 4'd0;
  logic [3:0]  exp_q[$];
  logic        draw_now;

  random_design dut (
    .CLK (CLK),
    .CLR (CLR),
    .EN  (EN),
    .r3  (r3),
    .r2  (r2),
    .r1  (r1),
    .r0  (r0)
  );

  assign card_out = {r3, r2, r1, r0};

  always #5 CLK = ~CLK;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Drive one cycle, advance the model, then compare after the edge
  task automatic step(input logic clr, input logic en, input string name);
    CLR = clr;
    EN  = en;
    draw_now = 1'b0;
    if (!clr) begin
      m_lfsr = 16'hACE1;
      m_en_d = 1'b0;
      m_card = 4'd0;
      exp_q.delete();
    end else begin
      if (en && !m_en_d) begin
        exp_q.push_back(4'((m_lfsr % 16'd10) + 16'd1));
        draw_now = 1'b1;
      end
      m_en_d = en;
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge CLK);
    #1;
    if (draw_now && exp_q.size() > 0) begin
      m_card = exp_q.pop_front();
    end
    checks++;
    if (card_out !== m_card) begin
      errors++;
      $display("[TB] FAIL %s: r3..r0=%0d expected %0d", name, card_out, m_card);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, "reset_hold");
    end
    checks++;
    if (dut.lfsr !== 16'hACE1) begin
      errors++;
      $display("[TB] FAIL reset_lfsr: lfsr=%h expected ace1", dut.lfsr);
    end
  endtask

  task automatic test_first_draw();
    step(1'b1, 1'b1, "first_draw");
    checks++;
    if (card_out !== 4'd8) begin
      errors++;
      $display("[TB] FAIL first_draw_value: r3..r0=%0d expected 8", card_out);
    end
    step(1'b1, 1'b0, "first_draw_hold");
  endtask

  task automatic test_delayed_draw();
    step(1'b0, 1'b0, "delayed_reset");
    step(1'b1, 1'b0, "delayed_idle");
    step(1'b1, 1'b1, "delayed_draw");
    checks++;
    if (card_out !== 4'd10) begin
      errors++;
      $display("[TB] FAIL delayed_draw_value: r3..r0=%0d expected 10", card_out);
    end
    step(1'b1, 1'b0, "delayed_hold");
  endtask

  task automatic test_held_en();
    int draws = 0;
    for (int rep = 0; rep < 11; rep++) begin
      for (int c = 0; c < 6; c++) begin
        step(1'b1, (c < 2), "held_en");
        if (draw_now) begin
          draws++;
          checks++;
          if (card_out < 4'd1 || card_out > 4'd10) begin
            errors++;
            $display("[TB] FAIL held_en_range: r3..r0=%0d expected 1..10", card_out);
          end
        end
      end
    end
    checks++;
    if (draws != 11) begin
      errors++;
      $display("[TB] FAIL held_en_count: draws=%0d expected 11", draws);
    end
  endtask

  task automatic test_no_retrigger();
    step(1'b1, 1'b0, "retrig_idle");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, "retrig_held");
    end
    step(1'b1, 1'b0, "retrig_release");
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, "mid_idle");
    step(1'b1, 1'b1, "mid_draw");
    step(1'b1, 1'b1, "mid_held");
    step(1'b0, 1'b1, "mid_reset");
    checks++;
    if (card_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: r3..r0=%0d expected 0", card_out);
    end
    step(1'b1, 1'b1, "mid_after_release");
    checks++;
    if (card_out !== 4'd8) begin
      errors++;
      $display("[TB] FAIL mid_reset_redraw: r3..r0=%0d expected 8", card_out);
    end
    step(1'b1, 1'b0, "mid_hold");
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_first_draw();
    test_delayed_draw();
    step(1'b0, 1'b0, "pre_held_reset");
    test_held_en();
    test_no_retrigger();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_design.md
Name: random_design

Overview:
- Card-value random generator for the Indian Poker datapath.
- A free-running 16-bit LFSR advances every clock.
- On each rising edge of EN the block draws one card value, 1..10, and holds it on r3..r0 until the next draw.
- Downstream dealing/compare logic reads r3..r0 as a 4-bit unsigned card value; 0 means "no card drawn since reset".

Parameters:
- SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero (0 is replaced by 16'h0001).
- MAX_CARD, 10, number of distinct card values; output range is 1..MAX_CARD, MAX_CARD ≤ 15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  reset, synchronous, active-low. CLR=0 at a rising CLK edge resets the block.
- EN   input  1  draw request; a level, may stay high for several cycles.
- r3   output 1  card value bit 3 (MSB), registered.
- r2   output 1  card value bit 2, registered.
- r1   output 1  card value bit 1, registered.
- r0   output 1  card value bit 0 (LSB), registered.

Behaviour:
- State: lfsr[15:0], en_d (registered copy of EN), card[3:0] driving {r3,r2,r1,r0}.
- Reset (CLR=0 at edge):
  - lfsr <= SEED.
  - en_d <= 0.
  - card <= 0, so r3..r0 = 0000.
  - Reset wins over a simultaneous EN; a reset in the middle of a pulse clears everything.
- LFSR, every non-reset edge, regardless of EN:
  - Fibonacci form, x^16+x^14+x^13+x^11+1.
  - fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - lfsr <= {lfsr[14:0], fb}.
  - Period 65535; the all-zero state is unreachable.
- Edge detect: en_d <= EN every non-reset edge.
- Draw: at an edge where EN=1 and en_d=0:
  - card <= (lfsr mod MAX_CARD) + 1, using lfsr's pre-edge value.
  - Latency: new value visible immediately after that edge, 1 cycle from EN rising.
- EN held high for N cycles produces exactly one draw. EN must return low for ≥1 cycle before the next draw.
- EN high on the first edge after reset release counts as a rising edge, because en_d=0.
- No draw → card holds its value.
- The mod-10 of a 16-bit value is combinational (constant-divisor reduction); no multi-cycle divider.
- Outputs are purely registered; no combinational path from EN to r3..r0.

Decomposition:
- Package random_pkg:
  - LFSR_W=16.
  - DEFAULT_SEED=16'hACE1.
  - TAP mask (bits 15,13,12,10).
  - DEFAULT_MAX_CARD=10.
  - Function to_card(lfsr) returning (lfsr mod MAX_CARD)+1 as 4 bits.
- One sub-module, lfsr16:
  - Inputs: clock, sync active-low reset, seed.
  - Output: lfsr state.
  - Always enabled.
- Top contains the edge detector, draw register, and output bit split.

Test Plan:
- Reset: hold CLR=0 for 100 cycles with EN=0 → r3..r0=0000 throughout. Internal lfsr=16'hACE1 at release.
- First draw: CLR=1, and EN=1 on the first edge after release → card = (44257 mod 10)+1 = 8, so r3..r0=1000 after that edge.
- Delayed draw: EN=0 on the first post-release edge, EN=1 on the second (lfsr=16'h59C3=22979) → card=10, r3..r0=1010.
- Held EN: EN high for 2 cycles, then low 4 cycles, repeated 11 times →
  - exactly 11 updates, each 1 cycle after an EN rise;
  - every value in 1..10, never 0 or >10;
  - values match a reference model using the same LFSR.
- Hold/no-retrigger: EN held high for 20 cycles → a single update, after which the value is stable.
- Mid-operation reset: CLR=0 while EN=1 → r3..r0=0000 on that edge. After release, the same sequence as the first-draw case (8 on the first edge with EN=1).
